// File: rtl/reverser_pkg.sv
// Shared definitions for the reverser pipeline: permutation mode encoding.
package reverser_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS      = 2'b00;
  localparam mode_t MODE_BIT_REV   = 2'b01;
  localparam mode_t MODE_GRP_ORDER = 2'b10;
  localparam mode_t MODE_GRP_BITS  = 2'b11;

endpackage

// File: rtl/rev_perm.sv
// Combinational bit permutation selected per beat by a 2-bit mode.
// Every candidate permutation is pure wiring; only the final select is logic.
module rev_perm
  import reverser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  output logic [WIDTH-1:0] result
);

  localparam int NG = WIDTH / GROUP;

  logic [WIDTH-1:0] bit_rev;
  logic [WIDTH-1:0] grp_order;
  logic [WIDTH-1:0] grp_bits;

  // A width that does not split into whole groups has no meaningful group modes.
  if (WIDTH % GROUP != 0) begin : g_width_check
    $error("rev_perm: WIDTH must be a multiple of GROUP");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    localparam int G = i / GROUP;
    localparam int K = i % GROUP;
    assign bit_rev[i]   = data[WIDTH-1-i];
    assign grp_order[i] = data[(NG-1-G)*GROUP + K];
    assign grp_bits[i]  = data[G*GROUP + (GROUP-1-K)];
  end

  // Pick the permuted word that matches the beat's mode.
  always_comb begin
    result = data;
    case (mode)
      MODE_PASS:      result = data;
      MODE_BIT_REV:   result = bit_rev;
      MODE_GRP_ORDER: result = grp_order;
      MODE_GRP_BITS:  result = grp_bits;
      default:        result = data;
    endcase
  end

endmodule

// File: rtl/reverser_pipe.sv
// Two-stage ready/valid pipeline applying a per-beat bit permutation.
// S1 captures the raw beat, S2 holds the permuted result that drives the outputs.
// Backpressure ripples combinationally from out_ready to in_ready, so a full
// pipeline with a ready sink still accepts one beat per cycle.
module reverser_pipe
  import reverser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GROUP = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  mode_t            in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output mode_t            out_mode,
  output logic [CNT_W-1:0] beat_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  mode_t            s1_mode;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  mode_t            s2_mode;
  logic [WIDTH-1:0] perm_data;
  logic             s1_adv;
  logic             s2_adv;
  logic             in_fire;

  rev_perm #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) u_perm (
    .data   (s1_data),
    .mode   (s1_mode),
    .result (perm_data)
  );

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = rst_n && s1_adv;
    in_fire  = in_valid && in_ready;
  end

  // S1 captures the incoming beat and mode as-is.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
      end
    end
  end

  // S2 captures the permuted S1 beat; it holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_mode  <= MODE_PASS;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= perm_data;
        s2_mode <= s1_mode;
      end
    end
  end

  // Count every accepted input beat, wrapping naturally at the counter width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (in_fire) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_mode  = s2_mode;

endmodule
